cacheline_adaptor: RTL
======================

Name: cacheline_adaptor

Overview:
- Sits between the cache controller's physical-memory port and the burst-oriented main memory.
- Converts one line-wide read or write request into a fixed sequence of narrow burst beats.
- Reads: assembles the returned beats into one full line, then issues a single-cycle response.
- Writes: slices the latched line into beats and responds once the last beat is accepted.

Parameters:
- s_offset, 5, log2 bytes per cache line (line = 256 bits).
- s_line, 8*2**s_offset, line width in bits.
- s_burst, 64, width of one memory beat in bits.
- num_beats, s_line/s_burst (4), beats per line transfer.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- address_i  in  32  line request address from cache (low s_offset bits ignored).
- read_i  in  1  line read request, held until resp_o.
- write_i  in  1  line write-back request, held until resp_o.
- line_i  in  s_line  write-back line data.
- line_o  out  s_line  assembled read line.
- resp_o  out  1  one-cycle completion pulse to cache.
- address_o  out  32  burst base address = {address_i[31:s_offset], s_offset'b0}, latched.
- read_o  out  1  burst read strobe to memory.
- write_o  out  1  burst write strobe to memory.
- burst_o  out  s_burst  outgoing beat data.
- burst_i  in  s_burst  incoming beat data.
- resp_i  in  1  memory beat acknowledge, one per beat.

Behaviour:
- Reset (sync, active-high): state=IDLE, beat counter=0, read_o=write_o=resp_o=0, line_o=0, burst_o=0, address_o=0.
- States: IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE.
- IDLE:
  - write_i=1: latch line_i and aligned address, go WR_BURST.
  - Else read_i=1: latch aligned address, go RD_BURST.
  - Write has priority if both are asserted.
  - resp_i is ignored in IDLE.
- RD_BURST:
  - read_o=1.
  - On each cycle with resp_i=1: store burst_i into line bits [s_burst*k +: s_burst] (k = beat counter, beat 0 = least-significant), then k++.
  - When resp_i arrives with k=num_beats-1: go RD_DONE, k wraps to 0.
  - Cycles with resp_i=0 are wait states; the line and the counter hold.
- RD_DONE:
  - read_o=0, resp_o=1 for exactly one cycle.
  - line_o carries the full assembled line in that same cycle; the cache captures data on resp.
  - Then go IDLE.
  - line_o holds its value until the next read's first beat arrives.
- WR_BURST:
  - write_o=1, burst_o = latched line bits [s_burst*k +: s_burst].
  - Advance k on resp_i.
  - After the last beat is acknowledged: go WR_DONE, k wraps to 0.
- WR_DONE: write_o=0, resp_o=1 for one cycle, then go IDLE.
- Latency, zero-wait memory:
  - Request seen in IDLE at cycle 0.
  - Beats acknowledged in cycles 1-4.
  - resp_o in cycle 5.
- No re-trigger: the cache drops its request the cycle after resp_o, and the adaptor is in IDLE only from the following cycle.
- Inputs are latched at accept: address_i and line_i changes during a burst have no effect.
- A request deasserted mid-burst does not abort; the burst completes.
- Reset mid-burst: immediately return to IDLE with strobes low, even if memory is still responding. Partial read data is discarded and no resp_o is issued.
- address_o stays constant for the whole burst; memory increments the beat address internally.

Decomposition:
- Shared cache package holds:
  - enum cla_state_t {IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE}.
  - Constants S_OFFSET, S_LINE, S_BURST, NUM_BEATS.
- Single module.
- The beat counter and line shift/select logic stay inline; no sub-module is warranted.

Test Plan:
- Read, zero-wait: read_i=1, address_i=0x1234_5678, memory returns 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles.
  - address_o=0x1234_5660 throughout the burst.
  - resp_o high only in cycle 5.
  - line_o={0x44..,0x33..,0x22..,0x11..}.
- Write with waits: write_i=1, line_i={0xD..,0xC..,0xB..,0xA..}, memory inserts 2 idle cycles before each resp_i.
  - burst_o=0xA.., 0xB.., 0xC.., 0xD.. in order, each held until its ack.
  - write_o deasserted in WR_DONE.
  - Exactly one resp_o.
- Back-to-back (write-back then refill, as in a dirty miss): write completes with resp_o, then read_i rises the next cycle.
  - Read starts from IDLE, no spurious beat.
  - Second resp_o after 4 more beats.
- Simultaneous read_i=write_i=1 in IDLE: write burst is taken (write_o=1, read_o=0).
- Reset at beat 2 of a read: rst=1 for one cycle.
  - Next cycle read_o=0, resp_o=0, line_o=0.
  - A fresh read afterwards completes correctly from beat 0.
- Stray resp_i=1 while IDLE: no state change, resp_o stays 0.

Source files
------------

// File: rtl/cacheline_adaptor_pkg.sv
// Shared definitions for the cache line <-> memory burst adaptor:
// geometry constants, the FSM state encoding and the address aligner.
package cacheline_adaptor_pkg;

  localparam int S_OFFSET  = 5;                    // log2 bytes per line
  localparam int S_LINE    = 8 * (2 ** S_OFFSET);  // line width in bits
  localparam int S_BURST   = 64;                   // beat width in bits
  localparam int NUM_BEATS = S_LINE / S_BURST;     // beats per line
  localparam int BEAT_W    = $clog2(NUM_BEATS);    // beat counter width

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_BURST = 3'd1,
    RD_DONE  = 3'd2,
    WR_BURST = 3'd3,
    WR_DONE  = 3'd4
  } cla_state_t;

  // Line-aligned base address: memory walks the beats internally, so the
  // adaptor only ever presents the first byte of the line.
  function automatic logic [31:0] align_addr(input logic [31:0] addr);
    return {addr[31:S_OFFSET], {S_OFFSET{1'b0}}};
  endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts one line-wide read/write request from the cache into a fixed
// sequence of NUM_BEATS memory beats, and back.
//
// Handshake: the cache holds read_i/write_i until resp_o, a one-cycle
// completion pulse. Towards memory, read_o/write_o stay high for the whole
// burst and every cycle with resp_i=1 transfers exactly one beat; cycles
// with resp_i=0 are wait states in which nothing advances. resp_i outside
// a burst is ignored.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
(
  input  logic                clk,
  input  logic                rst,

  // cache side
  input  logic [31:0]         address_i,
  input  logic                read_i,
  input  logic                write_i,
  input  logic [S_LINE-1:0]   line_i,
  output logic [S_LINE-1:0]   line_o,
  output logic                resp_o,

  // memory side
  output logic [31:0]         address_o,
  output logic                read_o,
  output logic                write_o,
  output logic [S_BURST-1:0]  burst_o,
  input  logic [S_BURST-1:0]  burst_i,
  input  logic                resp_i,

  // debug visibility of the FSM
  output cla_state_t          dbg_state
);

  cla_state_t                state, state_next;
  logic [BEAT_W-1:0]         beat_cnt;
  logic [S_LINE-1:0]         rd_line;   // read assembly buffer, also line_o
  logic [S_LINE-1:0]         wr_line;   // line latched at write accept
  logic [31:0]               addr_q;
  logic                      last_beat;

  assign last_beat = (beat_cnt == BEAT_W'(NUM_BEATS - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: request latching, beat counter and read line assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      rd_line  <= '0;
      wr_line  <= '0;
      addr_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Write wins over read when both are requested.
          if (write_i) begin
            wr_line <= line_i;
            addr_q  <= align_addr(address_i);
          end else if (read_i) begin
            addr_q  <= align_addr(address_i);
          end
        end
        RD_BURST: begin
          if (resp_i) begin
            rd_line[int'(beat_cnt)*S_BURST +: S_BURST] <= burst_i;
            beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_W'(1);
          end
        end
        WR_BURST: begin
          if (resp_i) begin
            beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state and state-decoded strobes.
  always_comb begin
    state_next = state;
    read_o     = 1'b0;
    write_o    = 1'b0;
    resp_o     = 1'b0;
    burst_o    = '0;
    case (state)
      IDLE: begin
        if (write_i)     state_next = WR_BURST;
        else if (read_i) state_next = RD_BURST;
      end
      RD_BURST: begin
        read_o = 1'b1;
        if (resp_i && last_beat) state_next = RD_DONE;
      end
      RD_DONE: begin
        resp_o     = 1'b1;
        state_next = IDLE;
      end
      WR_BURST: begin
        write_o = 1'b1;
        burst_o = wr_line[int'(beat_cnt)*S_BURST +: S_BURST];
        if (resp_i && last_beat) state_next = WR_DONE;
      end
      WR_DONE: begin
        resp_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign line_o    = rd_line;
  assign address_o = addr_q;
  assign dbg_state = state;

endmodule
